// File: rtl/piano_pkg.sv
// Shared constants and types for the Bluetooth piano command path.
// ASCII command bytes, octave/note types and the decoder FSM states.
package piano_pkg;

    localparam logic [7:0] NOTE_FIRST = 8'h31;
    localparam logic [7:0] NOTE_LAST  = 8'h37;
    localparam logic [7:0] STOP       = 8'h30;
    localparam logic [7:0] OCT_L_UC   = 8'h4C;
    localparam logic [7:0] OCT_L_LC   = 8'h6C;
    localparam logic [7:0] OCT_M_UC   = 8'h4D;
    localparam logic [7:0] OCT_M_LC   = 8'h6D;
    localparam logic [7:0] OCT_H_UC   = 8'h48;
    localparam logic [7:0] OCT_H_LC   = 8'h68;
    localparam logic [7:0] CR         = 8'h0D;
    localparam logic [7:0] LF         = 8'h0A;

    localparam int NOTES_PER_OCTAVE = 7;

    typedef enum logic [1:0] {
        OCT_LOW  = 2'd0,
        OCT_MID  = 2'd1,
        OCT_HIGH = 2'd2
    } octave_e;

    typedef logic [4:0] note_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_DECODE,
        ST_HOLD
    } state_e;

    // Note digits '1'..'7' carry their index in the low three bits.
    function automatic note_t note_code(input logic [1:0] oct, input logic [7:0] b);
        return note_t'(oct) * note_t'(NOTES_PER_OCTAVE) + note_t'(b[2:0]);
    endfunction

endpackage

// File: rtl/bt_byte_strobe.sv
// Detects byte completion on the falling edge of the UART busy flag and
// captures the byte, presenting it with a one-cycle valid the following cycle.
module bt_byte_strobe (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] data_i,
    input  logic       state_i,
    output logic       strobe_o,
    output logic [7:0] byte_o,
    output logic       vld_o
);

    logic       state_q;
    logic       vld_q;
    logic [7:0] byte_q;

    // History resets low so a flag that is already low never strobes.
    assign strobe_o = state_q & ~state_i;
    assign byte_o   = byte_q;
    assign vld_o    = vld_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= 1'b0;
            vld_q   <= 1'b0;
            byte_q  <= 8'h00;
        end else begin
            state_q <= state_i;
            vld_q   <= strobe_o;
            if (strobe_o) byte_q <= data_i;
        end
    end

endmodule

// File: rtl/bt_note_decoder.sv
// Decodes UART command bytes into a held piano note code plus octave.
// Optional BT_ERRCNT_EN adds a saturating 8-bit count of rejected bytes.
module bt_note_decoder
    import piano_pkg::*;
#(
    parameter int HOLD_CYCLES    = 50_000_000,
    parameter int DEFAULT_OCTAVE = 1
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic [7:0] iData,
    input  logic       iState,
    output logic [4:0] oNote,
    output logic       oNoteValid,
    output logic [1:0] oOctave,
`ifdef BT_ERRCNT_EN
    output logic [7:0] oErrCnt,
`endif
    output logic       oErr
);

    localparam int TW = $clog2(HOLD_CYCLES);
    localparam logic [TW-1:0] TMR_LOAD = TW'(HOLD_CYCLES - 1);

    logic          strobe, byte_vld, decode_en;
    logic [7:0]    byte_q;
    state_e        state_q, state_d;
    note_t         note_q, note_d;
    logic          vld_q, vld_d, err_q, err_d;
    logic [1:0]    oct_q, oct_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          is_note, is_stop;

    bt_byte_strobe u_strobe (
        .clk_i    (iClk),
        .rst_i    (iRst),
        .data_i   (iData),
        .state_i  (iState),
        .strobe_o (strobe),
        .byte_o   (byte_q),
        .vld_o    (byte_vld)
    );

    always_ff @(posedge iClk) begin
        if (iRst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (strobe) state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_DECODE;
            ST_DECODE:  state_d = vld_d ? ST_HOLD : ST_IDLE;
            ST_HOLD: begin
                if (strobe)      state_d = ST_CAPTURE;
                else if (!vld_d) state_d = ST_IDLE;
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        decode_en = (state_q == ST_CAPTURE) && byte_vld;
    end

    always_comb begin
        is_note = 1'b0;
        is_stop = 1'b0;
        err_d   = 1'b0;
        oct_d   = oct_q;
        if (decode_en) begin
            if (byte_q >= NOTE_FIRST && byte_q <= NOTE_LAST) begin
                is_note = 1'b1;
            end else begin
                case (byte_q)
                    STOP:               is_stop = 1'b1;
                    OCT_L_UC, OCT_L_LC: oct_d   = OCT_LOW;
                    OCT_M_UC, OCT_M_LC: oct_d   = OCT_MID;
                    OCT_H_UC, OCT_H_LC: oct_d   = OCT_HIGH;
                    CR, LF:             ;
                    default:            err_d   = 1'b1;
                endcase
            end
        end
    end

    // A note decoded in the expiry cycle takes priority, so no silent gap.
    always_comb begin
        note_d  = note_q;
        vld_d   = vld_q;
        timer_d = (timer_q != '0) ? timer_q - TW'(1) : '0;
        if (is_note) begin
            note_d  = note_code(oct_q, byte_q);
            vld_d   = 1'b1;
            timer_d = TMR_LOAD;
        end else if (is_stop || (vld_q && timer_q == '0)) begin
            note_d  = '0;
            vld_d   = 1'b0;
            timer_d = '0;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            note_q  <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
            oct_q   <= 2'(DEFAULT_OCTAVE);
            timer_q <= '0;
        end else begin
            note_q  <= note_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
            oct_q   <= oct_d;
            timer_q <= timer_d;
        end
    end

`ifdef BT_ERRCNT_EN
    logic [7:0] errcnt_q;

    always_ff @(posedge iClk) begin
        if (iRst)                               errcnt_q <= 8'd0;
        else if (err_d && errcnt_q != 8'd255)   errcnt_q <= errcnt_q + 8'd1;
    end

    assign oErrCnt = errcnt_q;
`endif

    assign oNote      = note_q;
    assign oNoteValid = vld_q;
    assign oOctave    = oct_q;
    assign oErr       = err_q;

endmodule
